// File: rtl/bricks_pkg.sv
// -----------------------------------------------------------------------------
// bricks_pkg
// Shared types and constants for the Bricks game-flow controller.
//   state_t      : controller state encoding (the code is visible on the state port)
//   ROW_MISS     : ball row value meaning the ball left the field
//   BRICK_COUNT  : width of the brick map
//   step_period(): ball step period for a given level
// -----------------------------------------------------------------------------
package bricks_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SERVE       = 3'd1,
    PLAY        = 3'd2,
    PAUSE       = 3'd3,
    MISS        = 3'd4,
    LEVEL_CLEAR = 3'd5,
    GAME_OVER   = 3'd6
  } state_t;

  localparam logic [3:0] ROW_MISS    = 4'd15;
  localparam int         BRICK_COUNT = 56;

  // period = max(base_div - (level-1)*div_dec, min_div).
  // The reduction is compared against base_div first so the subtraction can
  // never wrap around; a level of 0 is treated like level 1.
  function automatic logic [31:0] step_period(
    input logic [31:0] base_div,
    input logic [31:0] div_dec,
    input logic [31:0] min_div,
    input logic [2:0]  level
  );
    logic [31:0] reduction;
    reduction = (level == 3'd0) ? 32'd0 : (32'(level) - 32'd1) * div_dec;
    if (reduction >= base_div) begin
      return min_div;
    end
    if ((base_div - reduction) < min_div) begin
      return min_div;
    end
    return base_div - reduction;
  endfunction

endpackage

// File: rtl/bricks_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// bricks_game_ctrl_if
// Bundle between the game-flow controller and its surroundings (buttons,
// ball/paddle/score datapath).
//   start, pause      : push-button levels
//   bricks            : current brick map, all-zero when the level is cleared
//   ball_row_index    : ball row, ROW_MISS when the ball was lost
//   step_tick         : one-cycle enable advancing ball/score logic
//   ball_reset        : holds the ball at its serve position
//   brick_reload      : one-cycle brick map refill pulse
//   score_clear       : one-cycle score clear pulse
//   lives, level      : game progress
//   state             : controller state code
//   game_over, won    : end-of-game flags
// master = controller side, slave = buttons/datapath side.
// -----------------------------------------------------------------------------
interface bricks_game_ctrl_if;

  logic                               start;
  logic                               pause;
  logic [bricks_pkg::BRICK_COUNT-1:0] bricks;
  logic [3:0]                         ball_row_index;

  logic       step_tick;
  logic       ball_reset;
  logic       brick_reload;
  logic       score_clear;
  logic [1:0] lives;
  logic [2:0] level;
  logic [2:0] state;
  logic       game_over;
  logic       won;

  modport master (
    input  start, pause, bricks, ball_row_index,
    output step_tick, ball_reset, brick_reload, score_clear,
           lives, level, state, game_over, won
  );

  modport slave (
    output start, pause, bricks, ball_row_index,
    input  step_tick, ball_reset, brick_reload, score_clear,
           lives, level, state, game_over, won
  );

endinterface

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Programmable step divider. cnt runs 0..period-1 while en is high and wraps.
//   clock, reset : system clock, asynchronous active-low reset
//   period       : divide ratio in clock cycles (>= 1)
//   en           : count enable; when low the count is frozen
//   clr          : synchronous clear, wins over en
//   wrap         : high in the cycle where cnt is the last count of a period
//                  and counting is enabled
// wrap is deliberately independent of clr: the controller derives clr from its
// next state, which itself depends on wrap.
// -----------------------------------------------------------------------------
module tick_divider (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] period,
  input  logic        en,
  input  logic        clr,
  output logic        wrap
);

  logic [31:0] cnt;

  // >= rather than == so a period that shrinks mid-count still wraps.
  assign wrap = en && (cnt >= (period - 32'd1));

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // simulation and mismatch against synthesis.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? 32'd0 : cnt + 32'd1;
    end
  end

endmodule

// File: rtl/bricks_game_ctrl.sv
// -----------------------------------------------------------------------------
// bricks_game_ctrl
// Game-flow controller for Bricks. Generates the ball step enable from the
// system clock, pulses brick reload / score clear, tracks lives and level and
// detects miss, level clear and game over.
//   clock, reset : system clock, asynchronous active-low reset
//   bus          : bricks_game_ctrl_if.master (buttons, datapath status,
//                  step/reset/reload/clear controls, game status)
// Parameters: BASE_DIV, DIV_DEC, MIN_DIV set the step period per level;
// SERVE_HOLD is the number of step periods spent in SERVE; LIVES and
// MAX_LEVEL size the game.
// -----------------------------------------------------------------------------
module bricks_game_ctrl
  import bricks_pkg::*;
#(
  parameter int unsigned BASE_DIV   = 25_000_000,
  parameter int unsigned DIV_DEC    = 2_500_000,
  parameter int unsigned MIN_DIV    = 5_000_000,
  parameter int unsigned SERVE_HOLD = 4,
  parameter int unsigned LIVES      = 3,
  parameter int unsigned MAX_LEVEL  = 7
) (
  input logic                clock,
  input logic                reset,
  bricks_game_ctrl_if.master bus
);

  state_t      state;
  state_t      state_next;

  logic        start_q;
  logic        pause_q;
  logic        start_edge;
  logic        pause_edge;

  logic [1:0]  lives;
  logic [2:0]  level;
  logic [31:0] serve_cnt;
  logic [31:0] period;

  logic        div_en;
  logic        div_clr;
  logic        wrap;
  logic        serve_done;

  logic        step_tick;
  logic        brick_reload;
  logic        score_clear;
  logic        won;
  logic        ball_reset;
  logic        game_over;

  // Rising-edge detection on the buttons; a held button yields one edge.
  assign start_edge = bus.start & ~start_q;
  assign pause_edge = bus.pause & ~pause_q;

  // Period follows the level register, so a new level takes effect from the
  // first SERVE cycle after the level clear.
  assign period = step_period(BASE_DIV, DIV_DEC, MIN_DIV, level);

  // The last wrap of the serve hold moves straight to PLAY, so SERVE lasts
  // exactly SERVE_HOLD full periods.
  assign serve_done = (state == SERVE) && wrap && (serve_cnt == (SERVE_HOLD - 1));

  tick_divider u_tick_divider (
    .clock  (clock),
    .reset  (reset),
    .period (period),
    .en     (div_en),
    .clr    (div_clr),
    .wrap   (wrap)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and combinational controls. Edges arriving where they have no
  // transition simply fall through and are lost.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    state_next = state;
    div_en     = 1'b0;
    div_clr    = 1'b0;
    ball_reset = 1'b1;
    game_over  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_edge) state_next = SERVE;
      end
      SERVE: begin
        if (serve_done) state_next = PLAY;
      end
      PLAY: begin
        // Level clear outranks a simultaneous miss; pause is lowest.
        if (bus.bricks == '0) begin
          state_next = LEVEL_CLEAR;
        end else if (bus.ball_row_index == ROW_MISS) begin
          state_next = MISS;
        end else if (pause_edge) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_edge) state_next = PLAY;
      end
      MISS: begin
        state_next = (lives == 2'd0) ? GAME_OVER : SERVE;
      end
      LEVEL_CLEAR: begin
        state_next = (level == 3'(MAX_LEVEL)) ? GAME_OVER : SERVE;
      end
      GAME_OVER: begin
        if (start_edge) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    div_en     = (state == SERVE) || (state == PLAY);
    ball_reset = !((state == PLAY) || (state == PAUSE));
    game_over  = (state == GAME_OVER);

    // Every state change restarts the step period, except the PLAY<->PAUSE
    // round trip which must resume mid-period.
    div_clr = (state_next != state) &&
              !((state == PLAY)  && (state_next == PAUSE)) &&
              !((state == PAUSE) && (state_next == PLAY));
  end

  // ---------------------------------------------------------------------------
  // Edge registers, counters, registered pulses and flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      lives        <= 2'(LIVES);
      level        <= 3'd1;
      serve_cnt    <= '0;
      step_tick    <= 1'b0;
      brick_reload <= 1'b0;
      score_clear  <= 1'b0;
      won          <= 1'b0;
    end else begin
      start_q <= bus.start;
      pause_q <= bus.pause;

      // Tick only when the period completes and PLAY is not being left.
      step_tick    <= (state == PLAY) && (state_next == PLAY) && wrap;
      // Pulses land in the first SERVE cycle.
      brick_reload <= (state_next == SERVE) &&
                      ((state == IDLE) || (state == LEVEL_CLEAR));
      score_clear  <= (state == IDLE) && (state_next == SERVE);

      if ((state != SERVE) || serve_done) begin
        serve_cnt <= '0;
      end else if (wrap) begin
        serve_cnt <= serve_cnt + 32'd1;
      end

      if ((state == GAME_OVER) && (state_next == IDLE)) begin
        lives <= 2'(LIVES);
        level <= 3'd1;
      end else if ((state == PLAY) && (state_next == MISS)) begin
        lives <= lives - 2'd1;
      end else if ((state == LEVEL_CLEAR) && (state_next == SERVE)) begin
        level <= level + 3'd1;
      end

      if ((state == LEVEL_CLEAR) && (state_next == GAME_OVER)) begin
        won <= 1'b1;
      end else if ((state == GAME_OVER) && (state_next != GAME_OVER)) begin
        won <= 1'b0;
      end
    end
  end

  assign bus.step_tick    = step_tick;
  assign bus.ball_reset   = ball_reset;
  assign bus.brick_reload = brick_reload;
  assign bus.score_clear  = score_clear;
  assign bus.lives        = lives;
  assign bus.level        = level;
  assign bus.state        = state;
  assign bus.game_over    = game_over;
  assign bus.won          = won;

endmodule

// File: tb/tb_bricks_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bricks_game_ctrl
// Scoreboard bench for bricks_game_ctrl with small divider parameters.
// The stimulus process queues the expected record of every output event
// (state change or pulse) before causing it; the monitor samples on the
// falling edge and compares each event it sees against the queue head,
// including the cycle distance from the previous event (-1 = not checked).
// -----------------------------------------------------------------------------
module tb_bricks_game_ctrl;
  import bricks_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  bricks_game_ctrl_if bus ();

  bricks_game_ctrl #(
    .BASE_DIV   (8),
    .DIV_DEC    (2),
    .MIN_DIV    (4),
    .SERVE_HOLD (2),
    .LIVES      (3),
    .MAX_LEVEL  (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         tag;
    logic [2:0] st;
    logic [1:0] lives;
    logic [2:0] level;
    logic       won;
    logic       step;
    logic       reload;
    logic       clear;
    int         gap;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  n_tag  = 0;

  // ---------------------------------------------------------------------------
  // Expectation helpers
  // ---------------------------------------------------------------------------
  task automatic exp_ev(input state_t st, input int lives, input int level,
                        input logic won, input logic step, input logic reload,
                        input logic clear, input int gap);
    ev_t e;
    e.tag    = n_tag;
    e.st     = st;
    e.lives  = 2'(lives);
    e.level  = 3'(level);
    e.won    = won;
    e.step   = step;
    e.reload = reload;
    e.clear  = clear;
    e.gap    = gap;
    n_tag++;
    exp_q.push_back(e);
  endtask

  task automatic exp_state(input state_t st, input int lives, input int level,
                           input logic won, input logic reload, input logic clear,
                           input int gap);
    exp_ev(st, lives, level, won, 1'b0, reload, clear, gap);
  endtask

  task automatic exp_tick(input int lives, input int level, input int gap);
    exp_ev(PLAY, lives, level, 1'b0, 1'b1, 1'b0, 1'b0, gap);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  int         cyc      = 0;
  int         last_cyc = 0;
  logic [2:0] prev_st  = 3'd0;
  bit         first    = 1'b1;

  task automatic check_ev(input int gap);
    ev_t  e;
    logic want_br;
    logic want_go;
    bit   ok;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event t=%0t got st=%0d step=%0b reload=%0b clear=%0b lives=%0d lvl=%0d gap=%0d, want no event",
               $time, bus.state, bus.step_tick, bus.brick_reload, bus.score_clear,
               bus.lives, bus.level, gap);
    end else begin
      e       = exp_q.pop_front();
      want_br = !((e.st == PLAY) || (e.st == PAUSE));
      want_go = (e.st == GAME_OVER);
      ok = (bus.state === e.st) && (bus.lives === e.lives) && (bus.level === e.level) &&
           (bus.won === e.won) && (bus.game_over === want_go) &&
           (bus.ball_reset === want_br) && (bus.step_tick === e.step) &&
           (bus.brick_reload === e.reload) && (bus.score_clear === e.clear) &&
           ((e.gap < 0) || (gap == e.gap));
      if (!ok) begin
        n_fail++;
        $display("FAIL ev%0d t=%0t got st=%0d lives=%0d lvl=%0d won=%0b go=%0b br=%0b step=%0b reload=%0b clear=%0b gap=%0d | want st=%0d lives=%0d lvl=%0d won=%0b go=%0b br=%0b step=%0b reload=%0b clear=%0b gap=%0d",
                 e.tag, $time, bus.state, bus.lives, bus.level, bus.won, bus.game_over,
                 bus.ball_reset, bus.step_tick, bus.brick_reload, bus.score_clear, gap,
                 e.st, e.lives, e.level, e.won, want_go, want_br, e.step, e.reload,
                 e.clear, e.gap);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (first || bus.step_tick || bus.brick_reload || bus.score_clear ||
          (bus.state != prev_st)) begin
        check_ev(cyc - last_cyc);
        first    = 1'b0;
        last_cyc = cyc;
      end
      prev_st = bus.state;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_tick(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock);
      if (bus.step_tick === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_tick no step_tick within %0d cycles (t=%0t)", budget, $time);
    end
  endtask

  task automatic press_start();
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset              = 1'b0;
    bus.start          = 1'b0;
    bus.pause          = 1'b0;
    bus.bricks         = '1;
    bus.ball_row_index = 4'd0;

    // Reset state.
    exp_state(IDLE, 3, 1, 1'b0, 1'b0, 1'b0, -1);
    step(3);
    reset = 1'b1;
    step(2);

    // Start: pulses, 16-cycle serve, ticks every 8 cycles. start is held
    // for three cycles to show only one edge is taken.
    exp_state(SERVE, 3, 1, 1'b0, 1'b1, 1'b1, -1);
    exp_state(PLAY, 3, 1, 1'b0, 1'b0, 1'b0, 16);
    exp_tick(3, 1, 8);
    exp_tick(3, 1, 8);
    bus.start = 1'b1;
    step(3);
    bus.start = 1'b0;
    wait_tick(100);
    wait_tick(20);

    // Pause at cnt=3, resume; next tick 5 cycles after the second edge.
    exp_state(PAUSE, 3, 1, 1'b0, 1'b0, 1'b0, 4);
    exp_state(PLAY, 3, 1, 1'b0, 1'b0, 1'b0, 7);
    exp_tick(3, 1, 4);
    exp_tick(3, 1, 8);
    step(3);
    bus.pause = 1'b1;
    step(5);
    bus.pause = 1'b0;
    step(2);
    bus.pause = 1'b1;
    step(1);
    bus.pause = 1'b0;
    wait_tick(20);
    wait_tick(20);

    // Two misses: lives 2 then 1, serve again without reload.
    for (int l = 2; l >= 1; l--) begin
      exp_state(MISS, l, 1, 1'b0, 1'b0, 1'b0, 2);
      exp_state(SERVE, l, 1, 1'b0, 1'b0, 1'b0, 1);
      exp_state(PLAY, l, 1, 1'b0, 1'b0, 1'b0, 16);
      exp_tick(l, 1, 8);
      step(1);
      bus.ball_row_index = ROW_MISS;
      step(1);
      bus.ball_row_index = 4'd0;
      wait_tick(60);
    end

    // Third miss ends the game, not won.
    exp_state(MISS, 0, 1, 1'b0, 1'b0, 1'b0, 2);
    exp_state(GAME_OVER, 0, 1, 1'b0, 1'b0, 1'b0, 1);
    step(1);
    bus.ball_row_index = ROW_MISS;
    step(1);
    bus.ball_row_index = 4'd0;
    step(4);

    // start held in GAME_OVER: one edge back to IDLE, no second edge.
    exp_state(IDLE, 3, 1, 1'b0, 1'b0, 1'b0, -1);
    bus.start = 1'b1;
    step(6);
    bus.start = 1'b0;
    step(2);

    // New game.
    exp_state(SERVE, 3, 1, 1'b0, 1'b1, 1'b1, -1);
    exp_state(PLAY, 3, 1, 1'b0, 1'b0, 1'b0, 16);
    exp_tick(3, 1, 8);
    press_start();
    wait_tick(60);

    // Clear level 1: reload, level 2, period 6.
    exp_state(LEVEL_CLEAR, 3, 1, 1'b0, 1'b0, 1'b0, 2);
    exp_state(SERVE, 3, 2, 1'b0, 1'b1, 1'b0, 1);
    exp_state(PLAY, 3, 2, 1'b0, 1'b0, 1'b0, 12);
    exp_tick(3, 2, 6);
    exp_tick(3, 2, 6);
    step(1);
    bus.bricks = '0;
    step(1);
    bus.bricks = '1;
    wait_tick(40);
    wait_tick(20);

    // Clear level 2 together with a miss: clear wins, lives kept, period 4.
    exp_state(LEVEL_CLEAR, 3, 2, 1'b0, 1'b0, 1'b0, 2);
    exp_state(SERVE, 3, 3, 1'b0, 1'b1, 1'b0, 1);
    exp_state(PLAY, 3, 3, 1'b0, 1'b0, 1'b0, 8);
    exp_tick(3, 3, 4);
    exp_tick(3, 3, 4);
    step(1);
    bus.bricks         = '0;
    bus.ball_row_index = ROW_MISS;
    step(1);
    bus.bricks         = '1;
    bus.ball_row_index = 4'd0;
    wait_tick(40);
    wait_tick(20);

    // Clear final level: game over, won.
    exp_state(LEVEL_CLEAR, 3, 3, 1'b0, 1'b0, 1'b0, 2);
    exp_state(GAME_OVER, 3, 3, 1'b1, 1'b0, 1'b0, 1);
    step(1);
    bus.bricks = '0;
    step(1);
    bus.bricks = '1;
    step(4);

    // Leaving GAME_OVER clears won and restores lives/level.
    exp_state(IDLE, 3, 1, 1'b0, 1'b0, 1'b0, -1);
    press_start();
    step(2);

    // Reset mid-PLAY at cnt=5: immediate reset values, then silence.
    exp_state(SERVE, 3, 1, 1'b0, 1'b1, 1'b1, -1);
    exp_state(PLAY, 3, 1, 1'b0, 1'b0, 1'b0, 16);
    exp_tick(3, 1, 8);
    press_start();
    wait_tick(60);
    exp_state(IDLE, 3, 1, 1'b0, 1'b0, 1'b0, 5);
    step(5);
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(30);

    // Every queued expectation must have been consumed.
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected got %0d pending events, want 0 (next ev%0d)",
               exp_q.size(), exp_q[0].tag);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
